keypad_matrix_emulator: RTL
===========================

# keypad_matrix_emulator

Synthesizable 4x4 keypad matrix emulator that plays the key-switch side of the matrix scan protocol. It accepts a key press request (row, column, hold time) over a ready/req handshake and drives the active-low row lines in response to the scanner's active-low column drive, exactly as a physical pressed key would. It sits in place of the physical keypad for self-test and hardware-in-the-loop runs of the whack-a-mole input path, and connects directly to the keyboard scanner's col/row_b pins.

## Interface
- HOLD_W, 16: width of the hold-time counter and of hold_cyc.
- BOUNCE_CYC, 8: cycles of contact chatter per edge; only used with KEY_BOUNCE_EN.

- clk_500k  in  1  scan clock, the same 500 kHz clock as the scanner.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  press request; accepted when req && ready at a rising edge.
- key_row  in  2  row index of the key to press, 0..3.
- key_col  in  2  column index of the key to press, 0..3.
- hold_cyc  in  HOLD_W  number of clk_500k cycles the contact stays closed.
- cancel  in  1  forces immediate release.
- col  in  4  scanner column drive, active low.
- row_b  out  4  row lines to the scanner, active low, idle 4'b1111.
- ready  out  1  high only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on return to IDLE.

## Operation
- States: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT. BOUNCE_IN and BOUNCE_OUT exist only with KEY_BOUNCE_EN.
- IDLE: ready=1 and contact=0.
  - On accept, latch key_row, key_col and hold_cyc into r_row, r_col and r_hold.
  - Then go to BOUNCE_IN, or to HOLD if bounce is compiled out.
- Latched values are held for the whole press. Input changes and req are ignored while busy.
- HOLD: contact=1.
  - Counter starts at 0 and increments each cycle.
  - Leave when counter == max(r_hold,1)-1, so hold_cyc=0 behaves as 1.
  - Next state is BOUNCE_OUT, or IDLE if bounce is compiled out.
- BOUNCE_IN / BOUNCE_OUT: contact = bounce counter bit 0, which toggles every cycle.
  - The state lasts BOUNCE_CYC cycles.
  - BOUNCE_IN goes to HOLD. BOUNCE_OUT goes to IDLE.
- Entering IDLE from any state asserts done for one cycle. ready rises in that same cycle.
- cancel is sampled in any busy state. It goes to IDLE next edge with contact=0 and done pulsed, and BOUNCE_OUT is skipped. cancel in IDLE has no effect.
- Row drive is combinational from col, so a scanner that changes col and samples row on the next edge sees a consistent response:
  - row_b[i] = 0 when contact=1, i==r_row and col[r_col]==0.
  - Otherwise row_b[i] = 1.
  - If col=4'b0000 (scanner idle probe), the pressed row reads low.
- Only one key is emulated; ghosting and multi-key presses are not modelled.
- Counter widths:
  - hold counter is HOLD_W bits.
  - bounce counter is clog2(BOUNCE_CYC)+1 bits.
  - No wrap is possible because the terminal compare ends the state.

## Timing
- Reset values: row_b=4'b1111, ready=1, busy=0, done=0. State is IDLE and all counters are 0.
- Reset mid-press releases row_b within the same cycle, since contact is a flop cleared asynchronously.
- Accept at edge N:
  - Without KEY_BOUNCE_EN: contact=1 for cycles N+1 .. N+max(hold,1).
  - With KEY_BOUNCE_EN: contact=1 for cycles N+1+BOUNCE_CYC .. N+BOUNCE_CYC+max(hold,1).
- done is high in the first IDLE cycle. A new req may be accepted at that same edge; back-to-back presses are allowed.
- row_b has zero-cycle latency from col, and one cycle from a state change (contact is registered).

## Configuration
- KEY_BOUNCE_EN defined: the BOUNCE_IN and BOUNCE_OUT states are built. Each closure and release of the contact chatters for BOUNCE_CYC cycles.
- KEY_BOUNCE_EN undefined: the bounce states and bounce counter are removed. The contact closes and opens cleanly. BOUNCE_CYC is ignored.

## Test plan
- Reset asserted mid-HOLD (contact=1, col=4'b1101) -> row_b=4'b1111 immediately; ready=1 after release.
- No bounce; press row 2, col 1, hold 100; col driven 4'b1101 -> row_b=4'b1011 for exactly 100 cycles; done pulse at cycle 101.
  - With col=4'b1110 in the same window -> row_b=4'b1111.
- Scanner loop-back with the keyboard scanner, press (3,0) hold 2000 -> scanner row_location=3, col_location=0 during the press; both return to 4 after release.
- hold_cyc=0 -> contact high for 1 cycle. req while busy -> ignored, latched key unchanged. cancel at hold cycle 10 -> row_b=4'b1111 next cycle, done pulsed once.
- KEY_BOUNCE_EN, BOUNCE_CYC=8, hold 20 -> 8 alternating contact cycles, then 20 solid cycles, then 8 alternating cycles; done at cycle 37 after accept.

Source files
------------

// File: rtl/keypad_matrix_emulator.sv
// Emulates one pressed key of a 4x4 active-low keypad matrix; row_b follows col combinationally, contact is registered (1-cycle state latency).
// Requests accepted only while ready (IDLE); req is ignored while busy. Define KEY_BOUNCE_EN to add contact chatter on closure and release.
module keypad_matrix_emulator #(
   parameter int HOLD_W     = 16,
   parameter int BOUNCE_CYC = 8
) (
   input  logic              clk_500k,
   input  logic              rst,
   input  logic              req,
   input  logic [1:0]        key_row,
   input  logic [1:0]        key_col,
   input  logic [HOLD_W-1:0] hold_cyc,
   input  logic              cancel,
   input  logic [3:0]        col,
   output logic [3:0]        row_b,
   output logic              ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_BOUNCE_IN  = 2'd1,
      S_HOLD       = 2'd2,
      S_BOUNCE_OUT = 2'd3
   } state_t;

   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   if (BOUNCE_CYC < 1) begin : g_bounce_cyc_check
      $error("BOUNCE_CYC must be at least 1");
   end

   state_t            state_q, state_d;
   logic [1:0]        r_row_q, r_row_d;
   logic [1:0]        r_col_q, r_col_d;
   logic [HOLD_W-1:0] r_hold_q, r_hold_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [HOLD_W-1:0] hold_last;
   logic              contact_q, contact_d;
   logic              done_q, done_d;

`ifdef KEY_BOUNCE_EN
   localparam int                BCNT_W    = $clog2(BOUNCE_CYC) + 1;
   localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BOUNCE_CYC - 1);

   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
`endif

   // A zero hold request still closes the contact for one cycle.
   assign hold_last = (r_hold_q == '0) ? '0 : (r_hold_q - HOLD_ONE);

   always_ff @(posedge clk_500k or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         r_row_q    <= 2'd0;
         r_col_q    <= 2'd0;
         r_hold_q   <= '0;
         hold_cnt_q <= '0;
         contact_q  <= 1'b0;
         done_q     <= 1'b0;
`ifdef KEY_BOUNCE_EN
         bcnt_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         r_row_q    <= r_row_d;
         r_col_q    <= r_col_d;
         r_hold_q   <= r_hold_d;
         hold_cnt_q <= hold_cnt_d;
         contact_q  <= contact_d;
         done_q     <= done_d;
`ifdef KEY_BOUNCE_EN
         bcnt_q     <= bcnt_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      r_row_d    = r_row_q;
      r_col_d    = r_col_q;
      r_hold_d   = r_hold_q;
      hold_cnt_d = hold_cnt_q;
      done_d     = 1'b0;
      contact_d  = 1'b0;
`ifdef KEY_BOUNCE_EN
      bcnt_d     = bcnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (req) begin
               r_row_d    = key_row;
               r_col_d    = key_col;
               r_hold_d   = hold_cyc;
               hold_cnt_d = '0;
`ifdef KEY_BOUNCE_EN
               bcnt_d     = '0;
               state_d    = S_BOUNCE_IN;
`else
               state_d    = S_HOLD;
`endif
            end
         end
`ifdef KEY_BOUNCE_EN
         S_BOUNCE_IN: begin
            if (bcnt_q == BCNT_LAST) begin
               bcnt_d     = '0;
               hold_cnt_d = '0;
               state_d    = S_HOLD;
            end else begin
               bcnt_d = bcnt_q + BCNT_ONE;
            end
         end
`endif
         S_HOLD: begin
            if (hold_cnt_q == hold_last) begin
               hold_cnt_d = '0;
`ifdef KEY_BOUNCE_EN
               bcnt_d     = '0;
               state_d    = S_BOUNCE_OUT;
`else
               state_d    = S_IDLE;
               done_d     = 1'b1;
`endif
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
         end
`ifdef KEY_BOUNCE_EN
         S_BOUNCE_OUT: begin
            if (bcnt_q == BCNT_LAST) begin
               bcnt_d  = '0;
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               bcnt_d = bcnt_q + BCNT_ONE;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Cancel overrides every busy-state transition, skipping release chatter.
      if (cancel && (state_q != S_IDLE)) begin
         state_d    = S_IDLE;
         done_d     = 1'b1;
         hold_cnt_d = '0;
`ifdef KEY_BOUNCE_EN
         bcnt_d     = '0;
`endif
      end

      // Contact is registered, so it is derived from the upcoming state.
`ifdef KEY_BOUNCE_EN
      contact_d = (state_d == S_HOLD) ||
                  (((state_d == S_BOUNCE_IN) || (state_d == S_BOUNCE_OUT)) && bcnt_d[0]);
`else
      contact_d = (state_d == S_HOLD);
`endif
   end

   assign ready = (state_q == S_IDLE);
   assign busy  = ~ready;
   assign done  = done_q;

   always_comb begin
      row_b = 4'b1111;
      if (contact_q && !col[r_col_q]) begin
         row_b[r_row_q] = 1'b0;
      end
   end

endmodule
